// File: rtl/sa_pkg.sv
// Shared constants and types for the systolic-array front end.
// The N and DATAWIDTH defaults are also used by the PE array.
package sa_pkg;

    localparam int unsigned SA_N         = 8;
    localparam int unsigned SA_DATAWIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } skew_state_t;

endpackage

// File: rtl/sa_skew_lane.sv
// One skew lane: a DEPTH-stage {valid, data} shift chain.
// It has a synchronous clear and an asynchronous active-low reset.
module sa_skew_lane #(
    parameter int unsigned DEPTH     = 1,
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_valid,
    input  logic [DATAWIDTH-1:0] i_data,
    output logic                 o_valid,
    output logic [DATAWIDTH-1:0] o_data
);

    // Each stage holds {valid, data}. The chain shifts every cycle with no stall.
    logic [DEPTH-1:0][DATAWIDTH:0] r_stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else if (i_clr) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= {i_valid, i_data};
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_valid = r_stage[DEPTH-1][DATAWIDTH];
    assign o_data  = r_stage[DEPTH-1][DATAWIDTH-1:0];

endmodule

// File: rtl/sa_act_skewer.sv
// Activation skewer in front of the weight-stationary array.
// It delays element i by i+1 cycles, frames tiles, drains the skew and pulses tile_done.
module sa_act_skewer
    import sa_pkg::*;
#(
    parameter int unsigned N         = SA_N,
    parameter int unsigned DATAWIDTH = SA_DATAWIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [N*DATAWIDTH-1:0] s_data,
    input  logic                   s_last,
    input  logic                   flush,
    output logic [N*DATAWIDTH-1:0] out_A,
    output logic [N-1:0]           out_valid,
    output logic                   tile_done,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(N);

    skew_state_t        r_state;
    skew_state_t        w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_tile_done;
    logic               w_tile_done_nxt;
    logic               r_busy;
    logic               w_ready;
    logic               w_accept;

    // State, drain counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_tile_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tile_done <= w_tile_done_nxt;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    // Next-state logic. Flush overrides everything and also blocks acceptance.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_tile_done_nxt = 1'b0;
        w_ready         = 1'b0;
        w_accept        = 1'b0;
        if (flush) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            w_ready  = (r_state == IDLE) || (r_state == STREAM);
            w_accept = s_valid && w_ready;
            case (r_state)
                IDLE, STREAM: begin
                    if (w_accept) begin
                        w_state_nxt = s_last ? DRAIN : STREAM;
                        w_cnt_nxt   = '0;
                    end
                end
                DRAIN: begin
                    if (r_cnt == CNT_W'(N - 2)) begin
                        w_state_nxt     = IDLE;
                        w_cnt_nxt       = '0;
                        w_tile_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign s_ready   = w_ready;
    assign tile_done = r_tile_done;
    assign busy      = r_busy;

    // Lane i is i+1 stages deep. A non-accept cycle injects a zeroed bubble.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DATAWIDTH-1:0] w_lane_in;
        assign w_lane_in = w_accept ? s_data[gi*DATAWIDTH +: DATAWIDTH] : '0;

        sa_skew_lane #(
            .DEPTH     (gi + 1),
            .DATAWIDTH (DATAWIDTH)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clr   (flush),
            .i_valid (w_accept),
            .i_data  (w_lane_in),
            .o_valid (out_valid[gi]),
            .o_data  (out_A[gi*DATAWIDTH +: DATAWIDTH])
        );
    end

endmodule

// File: tb/tb_sa_act_skewer.sv
// Bench for sa_act_skewer with N=4: directed tiles followed by random traffic.
// Expected values come from a per-cycle history of accepted rows, flushes and resets.
module tb_sa_act_skewer;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MAXC = 1024;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic [N*DW-1:0] s_data;
    logic            s_last;
    logic            flush;
    logic [N*DW-1:0] out_A;
    logic [N-1:0]    out_valid;
    logic            tile_done;
    logic            busy;

    sa_act_skewer #(.N(N), .DATAWIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .flush     (flush),
        .out_A     (out_A),
        .out_valid (out_valid),
        .tile_done (tile_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: what was accepted in each cycle, and which cycles wiped the lanes.
    logic            hist_v [MAXC];
    logic [N*DW-1:0] hist_d [MAXC];
    bit              kill   [MAXC];
    int              cyc;
    int              drain_until;
    int              done_at;
    bit              in_tile;
    int              n_checks;
    int              n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit exp_ready(input logic f);
        return !f && (cyc >= drain_until);
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            int            src;
            logic          ev;
            logic [DW-1:0] ed;
            src = cyc - i - 1;
            ev  = 1'b0;
            ed  = '0;
            if (src >= 0 && hist_v[src]) begin
                ev = 1'b1;
                for (int f = src + 1; f < cyc; f++) begin
                    if (kill[f]) ev = 1'b0;
                end
                if (ev) ed = hist_d[src][i*DW +: DW];
            end
            chk($sformatf("lane%0d_valid", i), 32'(out_valid[i]), 32'(ev));
            chk($sformatf("lane%0d_data", i), 32'(out_A[i*DW +: DW]), 32'(ed));
        end
        chk("s_ready", 32'(s_ready), 32'(exp_ready(flush)));
        chk("busy", 32'(busy), 32'(in_tile || (cyc < drain_until)));
        chk("tile_done", 32'(tile_done), 32'(cyc == done_at));
    endtask

    task automatic model_update(input logic v, input logic l, input logic [N*DW-1:0] d, input logic f);
        logic acc;
        acc          = v && exp_ready(f);
        hist_v[cyc]  = acc;
        hist_d[cyc]  = acc ? d : '0;
        kill[cyc]    = f;
        if (f) begin
            in_tile     = 1'b0;
            drain_until = 0;
            done_at     = -1;
        end else if (acc) begin
            if (l) begin
                in_tile     = 1'b0;
                drain_until = cyc + N;
                done_at     = cyc + N;
            end else begin
                in_tile = 1'b1;
            end
        end
    endtask

    // One clock cycle: drive the inputs, check at the falling edge, then advance the model.
    task automatic step(input logic v, input logic l, input logic [N*DW-1:0] d, input logic f);
        s_valid = v;
        s_last  = l;
        s_data  = d;
        flush   = f;
        @(negedge clk);
        check_outputs();
        model_update(v, l, d, f);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [N*DW-1:0] row16(input int r);
        logic [N*DW-1:0] d;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(16 * r + i);
        return d;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_out_A"}, 32'(out_A), 32'(0));
        chk({tag, "_tile_done"}, 32'(tile_done), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        drain_until = 0;
        done_at     = -1;
        in_tile     = 1'b0;
        for (int k = 0; k < MAXC; k++) begin
            hist_v[k] = 1'b0;
            hist_d[k] = '0;
            kill[k]   = 1'b0;
        end
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        flush   = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // A tile of three back-to-back rows, with the last row flagged.
        step(1'b1, 1'b0, row16(0), 1'b0);
        step(1'b1, 1'b0, row16(1), 1'b0);
        step(1'b1, 1'b1, row16(2), 1'b0);
        idle(6);

        // A single-row tile goes straight to the drain.
        step(1'b1, 1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
        idle(6);

        // Two bubble cycles between rows A and B.
        step(1'b1, 1'b0, 32'hA3A2A1A0, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 32'hB3B2B1B0, 1'b0);
        idle(6);

        // A flush in the middle of the drain: the tile is abandoned.
        step(1'b1, 1'b0, row16(5), 1'b0);
        step(1'b1, 1'b1, row16(6), 1'b0);
        idle(1);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(6);

        // A flush in the same cycle as a valid beat: the beat is dropped.
        step(1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
        idle(6);

        // An asynchronous reset in the middle of streaming.
        step(1'b1, 1'b0, row16(8), 1'b0);
        step(1'b1, 1'b0, row16(9), 1'b0);
        s_valid = 1'b0;
        flush   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        hist_v[cyc] = 1'b0;
        kill[cyc]   = 1'b1;
        in_tile     = 1'b0;
        drain_until = 0;
        done_at     = -1;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        step(1'b1, 1'b0, row16(10), 1'b0);
        step(1'b1, 1'b1, row16(11), 1'b0);
        idle(6);

        // Random traffic, including occasional flushes.
        for (int k = 0; k < 400; k++) begin
            logic            v;
            logic            l;
            logic            f;
            logic [N*DW-1:0] d;
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 29) == 0);
            d = N*DW'($urandom);
            step(v, l, d, f);
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_act_skewer.md
# sa_act_skewer

Input staging stage directly upstream of the weight-stationary systolic array. It accepts one row vector of N int8 activations per beat over a valid/ready handshake. It emits N diagonally skewed lanes: lane i carries element i delayed by i+1 cycles, with a per-lane valid that drives the PE `in_A`/`valid_in` pair of array row i. It also frames tiles, drains the skew after the last row, and signals tile completion to the controller.

## Interface
- N, 8: array rows and skew depth; legal range N ≥ 2.
- DATAWIDTH, 8: activation element width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  skewer can accept a beat.
- s_data  in  N*DATAWIDTH  row vector; element i is bits [i*DATAWIDTH +: DATAWIDTH].
- s_last  in  1  beat is the final row of the tile; qualified by s_valid && s_ready.
- flush  in  1  synchronous abort; clears all state.
- out_A  out  N*DATAWIDTH  skewed lanes; lane i goes to array row i `in_A`.
- out_valid  out  N  per-lane valid; bit i goes to array row i `valid_in`.
- tile_done  out  1  single-cycle pulse when the last row exits lane N-1.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Accept condition: s_valid && s_ready && !flush.
- s_ready = (state ∈ {IDLE, STREAM}) && !flush. s_ready is combinational from state and flush, not from s_valid.
- Lane i is an (i+1)-stage delay line of {valid, data}. It shifts every cycle unconditionally. There are no stalls.
- A non-accept cycle in IDLE or STREAM injects a bubble, {valid=0, data=0}, into every lane. Bubbles keep the skew cycle-exact, and the downstream PE holds while valid is 0.
- Lanes are zero-filled, so out_A is 0 whenever out_valid is 0.
- FSM states:
  - IDLE: on accept with s_last=0, go to STREAM. On accept with s_last=1, go to DRAIN with cnt=0 (single-row tile).
  - STREAM: on accept with s_last=1, go to DRAIN with cnt=0. Otherwise stay.
  - DRAIN: s_ready=0 and bubbles are injected. cnt increments each cycle. When cnt == N-2, go to IDLE and register tile_done=1 for one cycle.
- cnt is $clog2(N) bits wide. It is only meaningful in DRAIN.
- flush, in any state, on the next edge:
  - clears all lane registers;
  - sets state to IDLE and cnt to 0;
  - forces tile_done to 0.
  - No beat is accepted during the flush cycle.
- Simultaneous events:
  - flush and accept in the same cycle: flush wins, because s_ready is low.
  - tile_done and the first beat of the next tile cannot coincide, because s_ready is low until IDLE is reached.
- Reset values: all lanes 0, out_A=0, out_valid=0, tile_done=0, busy=0, state IDLE, s_ready=1 after reset release.
- Reset mid-tile: in-flight rows are discarded and no tile_done is produced.

## Timing
- A beat accepted at edge T appears on lane i from edge T+i+1 and is held for exactly one cycle.
  - Lane 0 latency is 1 cycle.
  - Lane N-1 latency is N cycles.
- Consecutive accepted beats appear on each lane in consecutive cycles. Throughput is 1 row per cycle while streaming.
- Last beat accepted at edge T:
  - state is DRAIN after T; s_ready is low for the N-1 cycles following edges T..T+N-2.
  - tile_done is high for the cycle after edge T+N-1. This is the same cycle in which lane N-1 presents the last row, with out_valid[N-1]=1.
  - busy falls and s_ready rises in that same cycle.
  - The first beat of the next tile can be accepted at edge T+N at the earliest.
- All outputs except s_ready are registered.

## Structure
- Shared package `sa_pkg` holds:
  - the default N and DATAWIDTH constants, used by the PE array as well;
  - `skew_state_t`, an enum of IDLE, STREAM and DRAIN.
- Sub-module `sa_skew_lane`: parameterised by DEPTH and DATAWIDTH. It is a {valid, data} shift chain with synchronous clear and asynchronous reset. It is instantiated N times via generate with DEPTH = i+1.
- The top level holds the FSM, the drain counter, the tile_done register and the lane packing.

## Test plan
- N=4. Tile of 3 back-to-back rows with row r, element i = 16r+i; s_last on row 2 accepted at edge T.
  - Lane i shows 16r+i at edge T-2+r+i+1.
  - tile_done pulses after edge T+3.
  - s_ready is low for 3 cycles.
- Single-row tile: IDLE accept with s_last=1 and data {4,3,2,1}.
  - Goes directly to DRAIN.
  - Lane 3 shows 4 and tile_done=1 in the same cycle, 4 cycles after accept.
- Bubble insertion: s_valid=0 for 2 cycles between rows A and B.
  - Every lane shows A, two valid=0 cycles with data 0, then B.
  - Skew offsets are unchanged.
- flush asserted mid-DRAIN.
  - Next cycle: all out_valid=0, state IDLE, s_ready=1.
  - tile_done never pulses.
- flush and s_valid=1 in the same cycle: the beat is not accepted and no lane ever shows it.
- rst_n asserted asynchronously mid-STREAM: all outputs are 0 immediately, then normal streaming after release.
